musa_alu: RTL and testbench

- 32-bit integer ALU for the EX stage of the MUSA MIPS-style core.
- The ALU operation is selected by a 3-bit alu_control from the main decoder. When alu_control is 000, the 6-bit R-type func field selects the operation instead.
- result, flag and branch are registered: a single clock edge captures them.
- branch feeds the PC-select logic. flag feeds the status/exception logic.

---
 rtl/musa_alu_if.sv | 33 +++
 rtl/musa_alu.sv | 151 +++++++++++++++
 tb/tb_musa_alu.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/musa_alu_if.sv
// musa_alu_if: operand/result bundle between the EX-stage control and the ALU.
// master drives operands and the operation select; slave is the ALU side.
interface musa_alu_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] data_a;
    logic [WIDTH-1:0] data_b;
    logic [2:0]       alu_control;
    logic [5:0]       func;
    logic [WIDTH-1:0] result;
    logic [2:0]       flag;
    logic             branch;

    modport master (
        output data_a,
        output data_b,
        output alu_control,
        output func,
        input  result,
        input  flag,
        input  branch
    );

    modport slave (
        input  data_a,
        input  data_b,
        input  alu_control,
        input  func,
        output result,
        output flag,
        output branch
    );
endinterface

// File: rtl/musa_alu.sv
// musa_alu: registered 32-bit integer ALU for the MUSA EX stage.
// alu_control selects the operation class; 000 defers to the R-type func field.
// flag = {negative, signed overflow, zero}; branch = SUB with equal operands.
// Optional build macro ALU_OVF_SUPPRESS_EN: on signed overflow the result
// register keeps its previous value while flag and branch still update.
module musa_alu #(
    parameter int WIDTH = 32
) (
    input logic        clk,
    input logic        reset,
    musa_alu_if.slave  bus
);
    localparam logic [2:0] CTL_RTYPE = 3'b000;
    localparam logic [2:0] CTL_ADD   = 3'b001;
    localparam logic [2:0] CTL_SUB   = 3'b010;
    localparam logic [2:0] CTL_AND   = 3'b011;
    localparam logic [2:0] CTL_OR    = 3'b100;
    localparam logic [2:0] CTL_XOR   = 3'b101;
    localparam logic [2:0] CTL_SLT   = 3'b110;
    localparam logic [2:0] CTL_LUI   = 3'b111;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] slt_s;
    logic [WIDTH-1:0] slt_u;
    logic [WIDTH-1:0] shl;
    logic [WIDTH-1:0] shr;
    logic [WIDTH-1:0] sra;
    logic [WIDTH-1:0] lui;
    logic [4:0]       shamt;
    logic             add_ovf;
    logic             sub_ovf;

    logic [WIDTH-1:0] alu_out;
    logic             ovf;
    logic [WIDTH-1:0] next_result;
    logic [2:0]       next_flag;
    logic             next_branch;

    logic [WIDTH-1:0] result_q;
    logic [2:0]       flag_q;
    logic             branch_q;

    assign a     = bus.data_a;
    assign b     = bus.data_b;
    assign shamt = a[4:0];

    // Carry out is dropped; overflow is judged on sign bits only.
    assign sum     = a + b;
    assign diff    = a - b;
    assign add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    assign sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);

    assign slt_s = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
    assign slt_u = {{(WIDTH-1){1'b0}}, (a < b)};
    assign shl   = b << shamt;
    assign shr   = b >> shamt;
    assign sra   = $signed(b) >>> shamt;
    assign lui   = {b[15:0], {(WIDTH-16){1'b0}}};

    // Operation select: picks the raw result and whether it is a checked signed op.
    always_comb begin
        alu_out = '0;
        ovf     = 1'b0;
        case (bus.alu_control)
            CTL_RTYPE: begin
                case (bus.func)
                    FN_SLL, FN_SLLV: alu_out = shl;
                    FN_SRL, FN_SRLV: alu_out = shr;
                    FN_SRA, FN_SRAV: alu_out = sra;
                    FN_ADD: begin
                        alu_out = sum;
                        ovf     = add_ovf;
                    end
                    FN_ADDU: alu_out = sum;
                    FN_SUB: begin
                        alu_out = diff;
                        ovf     = sub_ovf;
                    end
                    FN_SUBU: alu_out = diff;
                    FN_AND:  alu_out = a & b;
                    FN_OR:   alu_out = a | b;
                    FN_XOR:  alu_out = a ^ b;
                    FN_NOR:  alu_out = ~(a | b);
                    FN_SLT:  alu_out = slt_s;
                    FN_SLTU: alu_out = slt_u;
                    default: alu_out = '0;
                endcase
            end
            CTL_ADD: begin
                alu_out = sum;
                ovf     = add_ovf;
            end
            CTL_SUB: begin
                alu_out = diff;
                ovf     = sub_ovf;
            end
            CTL_AND: alu_out = a & b;
            CTL_OR:  alu_out = a | b;
            CTL_XOR: alu_out = a ^ b;
            CTL_SLT: alu_out = slt_s;
            CTL_LUI: alu_out = lui;
        endcase
    end

`ifdef ALU_OVF_SUPPRESS_EN
    assign next_result = ovf ? result_q : alu_out;
`else
    assign next_result = alu_out;
`endif

    // Zero/negative describe whatever value the result register will hold.
    assign next_flag   = {next_result[WIDTH-1], ovf, (next_result == '0)};
    assign next_branch = (bus.alu_control == CTL_SUB) && (a == b);

    // Output registers with synchronous active-low reset taking priority.
    always_ff @(posedge clk) begin
        if (!reset) begin
            result_q <= '0;
            flag_q   <= 3'b000;
            branch_q <= 1'b0;
        end else begin
            result_q <= next_result;
            flag_q   <= next_flag;
            branch_q <= next_branch;
        end
    end

    assign bus.result = result_q;
    assign bus.flag   = flag_q;
    assign bus.branch = branch_q;
endmodule

// File: tb/tb_musa_alu.sv
// tb_musa_alu: directed vector table plus hand sequences for overflow and reset.
module tb_musa_alu;
    logic clk;
    logic reset;
    int   tests;
    int   fails;

    musa_alu_if #(.WIDTH(32)) bus ();

    musa_alu #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  ctl;
        logic [5:0]  fn;
        logic [31:0] er;
        logic [2:0]  ef;
        logic        eb;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic [31:0] a, input logic [31:0] b,
                                input logic [2:0] ctl, input logic [5:0] fn,
                                input logic [31:0] er, input logic [2:0] ef,
                                input logic eb);
        vec_t v;
        v.a = a; v.b = b; v.ctl = ctl; v.fn = fn;
        v.er = er; v.ef = ef; v.eb = eb;
        vecs.push_back(v);
    endfunction

    task automatic drive(input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] ctl, input logic [5:0] fn);
        bus.data_a      = a;
        bus.data_b      = b;
        bus.alu_control = ctl;
        bus.func        = fn;
    endtask

    task automatic check(input string name, input logic [31:0] er,
                         input logic [2:0] ef, input logic eb);
        tests++;
        if (bus.result !== er) begin
            fails++;
            $display("FAIL %s result: got %h expected %h", name, bus.result, er);
        end
        tests++;
        if (bus.flag !== ef) begin
            fails++;
            $display("FAIL %s flag: got %b expected %b", name, bus.flag, ef);
        end
        tests++;
        if (bus.branch !== eb) begin
            fails++;
            $display("FAIL %s branch: got %b expected %b", name, bus.branch, eb);
        end
    endtask

    // Drive inputs, let one edge capture them, sample just after the edge.
    task automatic step(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] ctl, input logic [5:0] fn,
                        input logic [31:0] er, input logic [2:0] ef, input logic eb);
        drive(a, b, ctl, fn);
        @(posedge clk);
        #1;
        check(name, er, ef, eb);
    endtask

    initial begin
        tests = 0;
        fails = 0;

        //   a             b             ctl     fn     result        flag    br
        add(32'h80000000, 32'h80000000, 3'b000, 6'h27, 32'h7FFFFFFF, 3'b000, 1'b0); // NOR
        add(32'h12345678, 32'h12345678, 3'b010, 6'h00, 32'h00000000, 3'b001, 1'b1); // SUB eq
        add(32'h12345678, 32'h12345679, 3'b010, 6'h00, 32'hFFFFFFFF, 3'b100, 1'b0); // SUB ne
        add(32'h00000004, 32'hF0000000, 3'b000, 6'h03, 32'hFF000000, 3'b100, 1'b0); // SRA
        add(32'h00000004, 32'hF0000000, 3'b000, 6'h02, 32'h0F000000, 3'b000, 1'b0); // SRL
        add(32'h00000000, 32'h0000ABCD, 3'b111, 6'h00, 32'hABCD0000, 3'b100, 1'b0); // LUI
        add(32'hFFFFFFFF, 32'h00000001, 3'b000, 6'h2A, 32'h00000001, 3'b000, 1'b0); // SLT
        add(32'hFFFFFFFF, 32'h00000001, 3'b000, 6'h2B, 32'h00000000, 3'b001, 1'b0); // SLTU
        add(32'hFFFFFFFF, 32'h00000001, 3'b000, 6'h3F, 32'h00000000, 3'b001, 1'b0); // bad func
        add(32'h00000000, 32'h12345678, 3'b000, 6'h00, 32'h12345678, 3'b000, 1'b0); // SLL by 0
        add(32'h0000001F, 32'h80000000, 3'b000, 6'h03, 32'hFFFFFFFF, 3'b100, 1'b0); // SRA by 31
        add(32'h00000024, 32'h0000000F, 3'b000, 6'h04, 32'h000000F0, 3'b000, 1'b0); // SLLV [4:0]
        add(32'h00000001, 32'h00000004, 3'b000, 6'h07, 32'h00000002, 3'b000, 1'b0); // SRAV
        add(32'h00000008, 32'h80000000, 3'b000, 6'h06, 32'h00800000, 3'b000, 1'b0); // SRLV
        add(32'h7FFFFFFF, 32'h00000001, 3'b000, 6'h21, 32'h80000000, 3'b100, 1'b0); // ADDU no ovf
        add(32'h80000000, 32'h00000001, 3'b000, 6'h23, 32'h7FFFFFFF, 3'b000, 1'b0); // SUBU no ovf
        add(32'h00000005, 32'hFFFFFFFD, 3'b000, 6'h20, 32'h00000002, 3'b000, 1'b0); // ADD
        add(32'hF0F0F0F0, 32'hFF00FF00, 3'b011, 6'h00, 32'hF000F000, 3'b100, 1'b0); // AND
        add(32'h0000000F, 32'h000000F0, 3'b100, 6'h00, 32'h000000FF, 3'b000, 1'b0); // OR
        add(32'hA5A5A5A5, 32'hA5A5A5A5, 3'b101, 6'h00, 32'h00000000, 3'b001, 1'b0); // XOR
        add(32'h00000001, 32'hFFFFFFFF, 3'b110, 6'h00, 32'h00000000, 3'b001, 1'b0); // SLT ctl
        add(32'hFFFF0000, 32'h0F0F0F0F, 3'b000, 6'h24, 32'h0F0F0000, 3'b000, 1'b0); // AND fn
        add(32'h00000001, 32'h00000002, 3'b000, 6'h25, 32'h00000003, 3'b000, 1'b0); // OR fn
        add(32'hFFFFFFFF, 32'h00000001, 3'b000, 6'h26, 32'hFFFFFFFE, 3'b100, 1'b0); // XOR fn
        add(32'h0000000A, 32'h00000014, 3'b001, 6'h00, 32'h0000001E, 3'b000, 1'b0); // ADD ctl
        add(32'h00000005, 32'h00000005, 3'b000, 6'h20, 32'h0000000A, 3'b000, 1'b0); // eq, not SUB ctl

        // Reset held for two edges with arbitrary live inputs.
        reset = 1'b0;
        drive(32'hDEADBEEF, 32'hDEADBEEF, 3'b010, 6'h27);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset", 32'h0, 3'b000, 1'b0);

        reset = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            step($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].ctl, vecs[i].fn,
                 vecs[i].er, vecs[i].ef, vecs[i].eb);
        end

        // Signed overflow: the preceding OR sets a known value the suppress build retains.
        step("ovf_pre", 32'h00001234, 32'h0, 3'b100, 6'h00, 32'h00001234, 3'b000, 1'b0);
`ifdef ALU_OVF_SUPPRESS_EN
        step("ovf_add", 32'h7FFFFFFF, 32'h00000001, 3'b001, 6'h00, 32'h00001234, 3'b010, 1'b0);
        step("ovf_sub", 32'h7FFFFFFF, 32'hFFFFFFFF, 3'b010, 6'h00, 32'h00001234, 3'b010, 1'b0);
        step("ovf_fsub", 32'h80000000, 32'h00000001, 3'b000, 6'h22, 32'h00001234, 3'b010, 1'b0);
`else
        step("ovf_add", 32'h7FFFFFFF, 32'h00000001, 3'b001, 6'h00, 32'h80000000, 3'b110, 1'b0);
        step("ovf_sub", 32'h7FFFFFFF, 32'hFFFFFFFF, 3'b010, 6'h00, 32'h80000000, 3'b110, 1'b0);
        step("ovf_fsub", 32'h80000000, 32'h00000001, 3'b000, 6'h22, 32'h7FFFFFFF, 3'b010, 1'b0);
`endif
        // Non-overflowing op afterwards writes normally in either build.
        step("ovf_post", 32'h00000003, 32'h00000004, 3'b001, 6'h00, 32'h00000007, 3'b000, 1'b0);

        // Reset beats an operation in the same cycle, including a taken branch.
        reset = 1'b0;
        step("rst_prio", 32'h00000009, 32'h00000009, 3'b010, 6'h00, 32'h0, 3'b000, 1'b0);
        // First edge after release captures the live inputs.
        reset = 1'b1;
        step("rst_rel", 32'h00000009, 32'h00000009, 3'b010, 6'h00, 32'h0, 3'b001, 1'b1);
        // Outputs hold between edges with no new edge.
        #3;
        check("hold", 32'h0, 3'b001, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
